// File: rtl/multicast_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : multicast_scheduler_if
// Description : Request/grant bundle between the input FIFOs / output ports
//               and the 4-port multicast crossbar scheduler.
//               req_valid  [3:0]   head-of-line packet present per input
//               req_target [15:0]  4-bit target mask per input (input i at 4i)
//               out_ready  [3:0]   output j can accept a packet this cycle
//               grant      [15:0]  bit 4i+j = input i drives output j
//               out_valid  [3:0]   output j carries a packet this cycle
//               out_src    [7:0]   winning input index per output (2j+1:2j)
//               pop        [3:0]   read-enable pulse back to input FIFO i
//               zero_tgt_cnt       saturating count of zero-target packets
//               master: FIFO/port side, slave: scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicast_scheduler_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req_valid;
  logic [15:0]      req_target;
  logic [3:0]       out_ready;
  logic [15:0]      grant;
  logic [3:0]       out_valid;
  logic [7:0]       out_src;
  logic [3:0]       pop;
  logic [CNT_W-1:0] zero_tgt_cnt;

  modport master (
    output req_valid, req_target, out_ready,
    input  grant, out_valid, out_src, pop, zero_tgt_cnt
  );

  modport slave (
    input  req_valid, req_target, out_ready,
    output grant, out_valid, out_src, pop, zero_tgt_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicast_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : multicast_scheduler
// Description : Crossbar scheduler for a 4-port switch. Each output keeps a
//               round-robin pointer over the inputs; each input keeps a mask
//               of targets already served for its head packet, so a
//               multicast packet is delivered target by target and popped
//               once every target has been served. Zero-target packets are
//               popped without a grant and counted (saturating).
// Ports       : clk, rst_n (async active-low), bus (slave modport, see
//               multicast_scheduler_if). CNT_W must match the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module multicast_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicast_scheduler_if.slave bus
);

  // Registered state
  logic [3:0]       r_served [NUM_PORTS];
  logic [1:0]       r_ptr    [NUM_PORTS];
  logic [15:0]      r_grant;
  logic [3:0]       r_out_valid;
  logic [7:0]       r_out_src;
  logic [3:0]       r_pop;
  logic [CNT_W-1:0] r_zero_cnt;

  // Combinational decision for the current cycle
  logic [3:0]       w_target  [NUM_PORTS];
  logic [3:0]       w_pend    [NUM_PORTS];
  logic [3:0]       w_win     [NUM_PORTS]; // [input][output]
  logic [3:0]       w_elig;
  logic [3:0]       w_win_any;
  logic [1:0]       w_win_idx [NUM_PORTS];
  logic [3:0]       w_zero;
  logic [3:0]       w_done;
  logic [2:0]       w_nzero;
  logic [CNT_W:0]   w_cnt_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign w_target[gi] = bus.req_target[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    // A popped head is stale for one cycle until the FIFO advances.
    w_elig = bus.req_valid & ~r_pop;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_pend[i] = w_elig[i] ? (w_target[i] & ~r_served[i]) : 4'b0000;
      w_win[i]  = 4'b0000;
    end

    // Per-output round-robin: scan from the pointer, first pending input wins.
    // The 2-bit index sum wraps 3 -> 0 naturally.
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_win_any[j] = 1'b0;
      w_win_idx[j] = r_ptr[j];
      if (bus.out_ready[j]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (!w_win_any[j] && w_pend[r_ptr[j] + 2'(k)][j]) begin
            w_win_any[j] = 1'b1;
            w_win_idx[j] = r_ptr[j] + 2'(k);
          end
        end
      end
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        w_win[i][j] = w_win_any[j] && (w_win_idx[j] == 2'(i));
      end
    end

    // Pop when every target bit is covered by earlier or current wins.
    w_nzero = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_zero[i] = w_elig[i] && (w_target[i] == 4'b0000);
      w_done[i] = w_elig[i] && (w_target[i] != 4'b0000) &&
                  ((w_target[i] & ~(r_served[i] | w_win[i])) == 4'b0000);
      w_nzero   = w_nzero + 3'(w_zero[i]);
    end
    w_cnt_sum = {1'b0, r_zero_cnt} + (CNT_W+1)'(w_nzero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_served[i] <= 4'b0000;
        r_ptr[i]    <= 2'd0;
      end
      r_grant     <= '0;
      r_out_valid <= '0;
      r_out_src   <= '0;
      r_pop       <= '0;
      r_zero_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_grant[i*4 +: 4] <= w_win[i];
        r_pop[i]          <= w_done[i] | w_zero[i];
        if (w_done[i]) begin
          r_served[i] <= 4'b0000;
        end else begin
          r_served[i] <= r_served[i] | w_win[i];
        end
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
        r_out_valid[j]     <= w_win_any[j];
        r_out_src[j*2 +: 2] <= w_win_any[j] ? w_win_idx[j] : 2'd0;
        if (w_win_any[j]) begin
          r_ptr[j] <= w_win_idx[j] + 2'd1;
        end
      end
      if (w_cnt_sum[CNT_W]) begin
        r_zero_cnt <= '1;
      end else begin
        r_zero_cnt <= w_cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign bus.grant        = r_grant;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_src      = r_out_src;
  assign bus.pop          = r_pop;
  assign bus.zero_tgt_cnt = r_zero_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicast_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicast_scheduler
// Description : Self-checking bench for multicast_scheduler. A reference model
//               tracks served targets and pointers per the scheduling rules;
//               a compare process checks every registered output each cycle,
//               and directed vectors pin hand-computed literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicast_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicast_scheduler_if #(.CNT_W(8)) bus ();

  multicast_scheduler #(.NUM_PORTS(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: which targets each head still needs, which input
  // each output favours next, and what must appear next cycle.
  // ------------------------------------------------------------------
  logic [3:0]  m_served [4];
  int          m_ptr    [4];
  logic [15:0] e_grant;
  logic [3:0]  e_valid;
  logic [7:0]  e_src;
  logic [3:0]  e_pop;
  int          e_cnt;
  logic [3:0]  need [4];
  logic [3:0]  got  [4];
  int          winner [4];
  int          nzero;
  int          cand;
  logic [3:0]  nxt_pop;
  logic [3:0]  tg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_served[i] = 4'b0;
        m_ptr[i]    = 0;
      end
      e_grant = '0; e_valid = '0; e_src = '0; e_pop = '0; e_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        tg      = bus.req_target[4*i +: 4];
        need[i] = (bus.req_valid[i] && !e_pop[i]) ? (tg & ~m_served[i]) : 4'b0;
        got[i]  = 4'b0;
      end
      e_grant = '0; e_valid = '0; e_src = '0;
      for (int j = 0; j < 4; j++) begin
        winner[j] = -1;
        if (bus.out_ready[j]) begin
          for (int k = 0; k < 4; k++) begin
            cand = (m_ptr[j] + k) % 4;
            if (winner[j] < 0 && need[cand][j]) winner[j] = cand;
          end
        end
        if (winner[j] >= 0) begin
          got[winner[j]][j]       = 1'b1;
          e_grant[4*winner[j]+j]  = 1'b1;
          e_valid[j]              = 1'b1;
          e_src[2*j +: 2]         = 2'(winner[j]);
          m_ptr[j]                = (winner[j] + 1) % 4;
        end
      end
      nzero = 0; nxt_pop = '0;
      for (int i = 0; i < 4; i++) begin
        tg = bus.req_target[4*i +: 4];
        if (bus.req_valid[i] && !e_pop[i]) begin
          if (tg == 4'b0) begin
            nxt_pop[i] = 1'b1;
            nzero++;
          end else if (((m_served[i] | got[i]) & tg) == tg) begin
            nxt_pop[i]  = 1'b1;
            m_served[i] = 4'b0;
          end else begin
            m_served[i] = m_served[i] | got[i];
          end
        end
      end
      e_pop = nxt_pop;
      e_cnt = (e_cnt + nzero > 255) ? 255 : e_cnt + nzero;
    end
  end

  always @(negedge clk) begin
    check("m_grant",  32'(bus.grant),        32'(e_grant));
    check("m_valid",  32'(bus.out_valid),    32'(e_valid));
    check("m_src",    32'(bus.out_src),      32'(e_src));
    check("m_pop",    32'(bus.pop),          32'(e_pop));
    check("m_cnt",    32'(bus.zero_tgt_cnt), 32'(e_cnt));
  end

  // Drive one cycle of inputs; returns at the next negedge, where the
  // registered result of that cycle is visible.
  task automatic drive(input logic [3:0] v, input logic [15:0] t, input logic [3:0] r);
    bus.req_valid  = v;
    bus.req_target = t;
    bus.out_ready  = r;
    @(negedge clk);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with random inputs
    for (int n = 0; n < 4; n++) begin
      bus.req_valid  = 4'($urandom);
      bus.req_target = 16'($urandom);
      bus.out_ready  = 4'($urandom);
      @(negedge clk);
    end
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_pop",   32'(bus.pop), 32'h0);
    check("rst_cnt",   32'(bus.zero_tgt_cnt), 32'h0);
    bus.req_valid = 4'b0;
    #2 rst_n = 1'b1;

    // Single unicast: input 0 -> output 2
    drive(4'b0001, 16'h0004, 4'b1111);
    check("uni_grant", 32'(bus.grant), 32'h0004);
    check("uni_src",   32'(bus.out_src[5:4]), 32'h0);
    check("uni_valid", 32'(bus.out_valid), 32'b0100);
    check("uni_pop",   32'(bus.pop), 32'b0001);
    drive(4'b0001, 16'h0004, 4'b1111);
    check("uni_noregrant", 32'(bus.grant), 32'h0);
    check("uni_pop_low",   32'(bus.pop), 32'h0);
    drive(4'b0000, 16'h0000, 4'b1111);

    // Contention on output 0, FIFOs refilled with the same target
    for (int n = 0; n < 5; n++) begin
      drive(4'b1111, 16'h1111, 4'b1111);
      check("rr_src",   32'(bus.out_src[1:0]), 32'(order[n]));
      check("rr_grant", 32'(bus.grant), 32'h1 << (4 * order[n]));
      check("rr_pop",   32'(bus.pop), 32'h1 << order[n]);
    end
    drive(4'b0000, 16'h0000, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b1111);

    // Multicast 1011 from input 1 under backpressure
    drive(4'b0010, 16'h00B0, 4'b0001);
    check("mc_grant1", 32'(bus.grant), 32'h0010);
    check("mc_pop1",   32'(bus.pop), 32'h0);
    drive(4'b0010, 16'h00B0, 4'b1011);
    check("mc_grant2", 32'(bus.grant), 32'h00A0);
    check("mc_pop2",   32'(bus.pop), 32'b0010);
    drive(4'b0010, 16'h00B0, 4'b1111);
    check("mc_stale",  32'(bus.grant), 32'h0);
    drive(4'b0000, 16'h0000, 4'b1111);

    // Move ptr_1 to 3 via input 2, then parallel wins
    drive(4'b0100, 16'h0200, 4'b0010);
    check("pw_setup", 32'(bus.grant), 32'h0200);
    drive(4'b0000, 16'h0000, 4'b1111);
    drive(4'b1001, 16'h2003, 4'b0011);
    check("pw_grant", 32'(bus.grant), 32'h2001);
    check("pw_src",   32'(bus.out_src), 32'h0C);
    check("pw_pop",   32'(bus.pop), 32'b1000);
    drive(4'b0001, 16'h0003, 4'b0011);
    check("pw_grant2", 32'(bus.grant), 32'h0002);
    check("pw_pop2",   32'(bus.pop), 32'b0001);
    drive(4'b0000, 16'h0000, 4'b1111);

    // Zero-target packets
    drive(4'b0100, 16'h0000, 4'b1111);
    check("zt_grant", 32'(bus.grant), 32'h0);
    check("zt_pop",   32'(bus.pop), 32'b0100);
    check("zt_cnt1",  32'(bus.zero_tgt_cnt), 32'd1);
    drive(4'b0000, 16'h0000, 4'b1111);
    drive(4'b1011, 16'h0000, 4'b1111);
    check("zt_cnt4",  32'(bus.zero_tgt_cnt), 32'd4);
    check("zt_pop3",  32'(bus.pop), 32'b1011);
    drive(4'b0000, 16'h0000, 4'b1111);
    for (int n = 0; n < 600; n++) drive(4'b0100, 16'h0000, 4'b1111);
    check("zt_sat", 32'(bus.zero_tgt_cnt), 32'd255);
    drive(4'b0000, 16'h0000, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b1111);

    // Reset in the middle of a multicast
    drive(4'b0001, 16'h000F, 4'b0011);
    check("mr_partial", 32'(bus.grant), 32'h0003);
    check("mr_nopop",   32'(bus.pop), 32'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mr_rst_grant", 32'(bus.grant), 32'h0);
    check("mr_rst_cnt",   32'(bus.zero_tgt_cnt), 32'h0);
    bus.req_valid = 4'b0000;
    #2 rst_n = 1'b1;
    drive(4'b0001, 16'h000F, 4'b1111);
    check("mr_full_grant", 32'(bus.grant), 32'h000F);
    check("mr_full_pop",   32'(bus.pop), 32'b0001);
    drive(4'b0000, 16'h0000, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
